// File: rtl/bcd_count_display.sv
// Up/down BCD counter with prescaled stepping, validated synchronous load and a
// registered seven-segment decode of the count (optional leading-zero blanking).
module bcd_count_display #(
    parameter int DIGITS     = 4,
    parameter int TOP        = 9999,
    parameter int DIV        = 1,
    parameter int ACTIVE_LOW = 1,
    parameter int BLANK_LZ   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  wrap,
    output logic                  load_err
);

    localparam int CW = 4 * DIGITS;
    localparam int SW = 7 * DIGITS;
    localparam int PW = 17;

    function automatic logic [CW-1:0] int_to_bcd(input int v);
        logic [CW-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Walk from the most significant digit so "any nonzero digit at or above k" is known.
    function automatic logic [SW-1:0] decode(input logic [CW-1:0] c);
        logic [SW-1:0] r;
        logic [6:0]    bits;
        logic          nz;
        r  = '0;
        nz = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            nz   = nz | (c[4*k +: 4] != 4'd0);
            bits = seg_pattern(c[4*k +: 4]);
            if (BLANK_LZ != 0 && k > 0 && !nz) bits = 7'h00;
            r[7*k +: 7] = (ACTIVE_LOW != 0) ? ~bits : bits;
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] c);
        logic [CW-1:0] r;
        logic          carry;
        r     = c;
        carry = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (carry) begin
                if (c[4*k +: 4] == 4'd9) begin
                    r[4*k +: 4] = 4'd0;
                end else begin
                    r[4*k +: 4] = c[4*k +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] c);
        logic [CW-1:0] r;
        logic          borrow;
        r      = c;
        borrow = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (borrow) begin
                if (c[4*k +: 4] == 4'd0) begin
                    r[4*k +: 4] = 4'd9;
                end else begin
                    r[4*k +: 4] = c[4*k +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    localparam logic [CW-1:0] TOP_BCD   = int_to_bcd(TOP);
    localparam logic [SW-1:0] RESET_SEG = decode({CW{1'b0}});
    localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [SW-1:0] seg_q, seg_d;
    logic          wrap_q, wrap_d;
    logic          load_err_q, load_err_d;
    logic          load_ok;
    logic          at_end;

    always_comb begin
        load_ok = (load_val <= TOP_BCD);
        for (int k = 0; k < DIGITS; k++) begin
            if (load_val[4*k +: 4] > 4'd9) load_ok = 1'b0;
        end
    end

    assign at_end = (presc_q == PRE_LAST);

    // A load, accepted or rejected, suppresses any step in the same cycle.
    always_comb begin
        count_d    = count_q;
        presc_d    = presc_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        seg_d      = decode(count_q);
        if (load) begin
            if (load_ok) begin
                count_d = load_val;
                presc_d = '0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (en) begin
            presc_d = at_end ? '0 : presc_q + PW'(1);
            if (at_end) begin
                if (up) begin
                    if (count_q == TOP_BCD) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = bcd_inc(count_q);
                    end
                end else begin
                    if (count_q == '0) begin
                        count_d = TOP_BCD;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = bcd_dec(count_q);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            presc_q    <= '0;
            seg_q      <= RESET_SEG;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            presc_q    <= presc_d;
            seg_q      <= seg_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign seg      = seg_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;

endmodule

// File: doc/bcd_count_display.md
BCD_COUNT_DISPLAY -- requirements
Module: bcd_count_display

Interface
REQ-001 Parameter DIGITS, default 4: number of BCD digits and seven-segment displays, legal range 1..8.
REQ-002 Parameter TOP, default 9999: terminal count as a decimal integer, legal range 1..(10^DIGITS)-1.
REQ-003 Parameter DIV, default 1: enabled cycles per count step, legal range 1..2^16.
REQ-004 Parameter ACTIVE_LOW, default 1: 1 = segment lit when bit is 0; 0 = segment lit when bit is 1.
REQ-005 Parameter BLANK_LZ, default 1: 1 = leading-zero blanking enabled.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 en  input  1  count enable, feeds the prescaler.
REQ-009 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-010 load  input  1  synchronous load strobe.
REQ-011 load_val  input  4*DIGITS  BCD load value, digit 0 in bits [3:0].
REQ-012 count  output  4*DIGITS  registered BCD count, digit 0 in bits [3:0].
REQ-013 seg  output  7*DIGITS  registered segment bus; per digit, bit 0 = a .. bit 6 = g.
REQ-014 wrap  output  1  one-cycle pulse on a count wrap-around.
REQ-015 load_err  output  1  one-cycle pulse on a rejected load.

Function
REQ-016 The prescaler SHALL count cycles with en=1 from 0 to DIV-1, hold its value while en=0, and generate step when en=1 and prescaler=DIV-1, then return to 0; with DIV=1, step = en.
REQ-017 On step with up=1: count=TOP -> count=0 with wrap=1 next cycle; otherwise count+1 in BCD with decimal carry between digits (9 -> 0 plus carry).
REQ-018 On step with up=0: count=0 -> count=TOP with wrap=1 next cycle; otherwise count-1 in BCD with decimal borrow (0 -> 9 plus borrow).
REQ-019 A change of up between steps SHALL take effect on the next step; the prescaler SHALL NOT be cleared.
REQ-020 load=1 SHALL take priority over step in the same cycle; a valid load writes count=load_val, clears the prescaler to 0, and produces no wrap.
REQ-021 A load SHALL be rejected when any nibble of load_val exceeds 9 or load_val exceeds TOP; count and prescaler are unchanged, and load_err=1 in the next cycle.
REQ-022 wrap and load_err SHALL be registered, high for exactly one cycle per event, and 0 otherwise.
REQ-023 Count SHALL never leave the range 0..TOP, and every nibble SHALL always be a legal BCD digit 0..9.
REQ-024 seg SHALL be a registered decode of count with one cycle of latency: seg in cycle n+1 reflects count in cycle n.
REQ-025 Active-high patterns (g..a) SHALL be 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F; when ACTIVE_LOW=1, every bit is inverted.
REQ-026 With BLANK_LZ=1, a digit k>0 SHALL be blank (all segments off, polarity per ACTIVE_LOW) when it and all higher digits are 0; digit 0 is never blanked.
REQ-027 With BLANK_LZ=0, every digit SHALL always show its decoded pattern.

Reset
REQ-028 With rst_n=0, count, prescaler, wrap and load_err SHALL go to 0 immediately, independent of clk.
REQ-029 With rst_n=0, seg SHALL go immediately to the decode of count=0 under the current BLANK_LZ and ACTIVE_LOW settings (defaults: digit 0 = 7'h40, others = 7'h7F).
REQ-030 Reset asserted mid-count or mid-prescale SHALL discard all progress; the first step after release occurs after DIV enabled cycles.
REQ-031 Inputs SHALL be ignored while rst_n=0, and the first rising edge after rst_n rises SHALL be a normal operating edge.

Verification
REQ-032 Defaults, en=1, up=1, 10001 cycles -> count cycles 0000..9999, wraps to 0000, exactly one wrap pulse at that wrap.
REQ-033 DIV=4, en toggled high 3 cycles, low 5 cycles, high 1 cycle -> exactly one step, count=0001.
REQ-034 count=0000, up=0, step -> count=9999, wrap=1; set TOP=0250 and repeat -> count=0250.
REQ-035 load_val=16'h12A4 -> load_err=1, count unchanged; load_val=16'h0199 with en=1 in the same cycle -> count=0199, no step applied.
REQ-036 count=0007 with defaults -> seg next cycle = {7F,7F,7F,78}; BLANK_LZ=0 -> {40,40,40,78}.
REQ-037 rst_n pulsed low between clock edges at count=0537 -> count=0000 and seg equals the reset pattern before the next edge.
